xor_descrambler_deserializer: RTL

- Receive end of the XOR-based serial link. Takes a bit-serial stream produced by a self-synchronizing PRBS7 scrambler (x^7 + x^6 + 1) and recovers each bit with XOR.
- Reassembles descrambled bits into WIDTH-bit words followed by one even-parity bit.
- Presents each word on a valid/ready output through a one-entry output buffer.
- Sits between the serial line sampler and the word-level consumer.

---
 rtl/xor_link_pkg.sv | 19 +
 rtl/prbs7_descrambler.sv | 24 ++
 rtl/xor_descrambler_deserializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/xor_link_pkg.sv
// Shared PRBS7 link definitions for the XOR scrambler/descrambler pair.
package xor_link_pkg;

  localparam int LFSR_LEN = 7;
  localparam int TAP_HI   = 6;
  localparam int TAP_LO   = 5;

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } rx_state_t;

  // Line history holds scrambled bits, so the same XOR scrambles and descrambles.
  function automatic logic descramble_bit(input logic                bit_in,
                                          input logic [LFSR_LEN-1:0] lfsr);
    return bit_in ^ lfsr[TAP_HI] ^ lfsr[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs7_descrambler.sv
// Self-synchronizing PRBS7 descrambler: history register fed with the raw line bits.
module prbs7_descrambler
  import xor_link_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic bit_en,
  output logic bit_out
);

  logic [LFSR_LEN-1:0] r_lfsr;

  assign bit_out = descramble_bit(bit_in, r_lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (bit_en) begin
      r_lfsr <= {r_lfsr[LFSR_LEN-2:0], bit_in};
    end
  end

endmodule

// File: rtl/xor_descrambler_deserializer.sv
// Serial PRBS7 descrambler and word deserializer with even-parity check and a
// one-entry valid/ready output buffer.
//
// state | meaning
// DATA  | collecting descrambled data bits into the shift register
// PAR   | waiting for the parity bit; its acceptance loads the output buffer
module xor_descrambler_deserializer
  import xor_link_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_parity_err,
  input  logic             m_ready
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             w_accept;
  logic             w_d;
  logic             w_store_bit;
  logic             w_load_word;

  // Only the parity bit can stall: it is the one that needs the output buffer.
  assign s_ready  = !(r_state == PAR && m_valid && !m_ready);
  assign w_accept = s_valid && s_ready;

  prbs7_descrambler u_descrambler (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (s_data),
    .bit_en  (w_accept),
    .bit_out (w_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DATA;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = DATA;
    end else if (w_accept) begin
      case (r_state)
        DATA:    if (r_bit_cnt == LAST_IDX) w_state_nxt = PAR;
        PAR:     w_state_nxt = DATA;
        default: w_state_nxt = DATA;
      endcase
    end
  end

  always_comb begin
    w_store_bit = 1'b0;
    w_load_word = 1'b0;
    if (w_accept && !flush) begin
      w_store_bit = (r_state == DATA);
      w_load_word = (r_state == PAR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
    end else begin
      if (flush) begin
        r_bit_cnt <= '0;
      end else if (w_store_bit) begin
        r_bit_cnt <= (r_bit_cnt == LAST_IDX) ? '0 : r_bit_cnt + 1'b1;
      end

      if (w_store_bit) begin
        r_shift[r_bit_cnt] <= w_d;
      end

      // A load in the drain cycle keeps m_valid high with the new word.
      if (w_load_word) begin
        m_valid      <= 1'b1;
        m_data       <= r_shift;
        m_parity_err <= (^r_shift) ^ w_d;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
